// File: rtl/led_frame_serializer_pkg.sv
// Shared types for the LED frame serializer: pixel colour type and FSM states.
package led_frame_serializer_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t BLACK = 24'h000000;

  typedef enum logic [1:0] {IDLE, SEEK, STREAM, DONE} ser_state_t;

endpackage

// File: rtl/led_frame_serializer_bin_cursor.sv
// Bin cursor: tracks the current bin, the pixels remaining in it and the
// black fill mode used once every bin has been consumed.
module led_bin_cursor
  import led_frame_serializer_pkg::*;
#(
  parameter int BIN_QTY = 12,
  parameter int CW      = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CW-1:0]               start_count,
  input  logic                        step_bin,
  input  logic                        dec,
  input  logic                        to_fill,
  input  logic [BIN_QTY-1:0][CW-1:0]  counts,
  input  rgb_t [BIN_QTY-1:0]          colours,
  output rgb_t                        colour,
  output logic                        fill,
  output logic                        r_zero,
  output logic                        r_one,
  output logic                        b_last
);

  localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BIN_QTY - 1);

  logic [BW-1:0] b_reg;
  logic [BW-1:0] b_inc;
  logic [CW-1:0] r_reg;
  logic          fill_reg;

  assign b_inc  = b_reg + 1'b1;
  assign colour = colours[b_reg];
  assign fill   = fill_reg;
  assign r_zero = (r_reg == '0);
  assign r_one  = (r_reg == CW'(1));
  assign b_last = (b_reg == B_LAST);

  // step_bin is only raised by the FSM while b_reg is below the last bin,
  // so counts[b_inc] never reads past the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_reg    <= '0;
      r_reg    <= '0;
      fill_reg <= 1'b0;
    end else if (start) begin
      b_reg    <= '0;
      r_reg    <= start_count;
      fill_reg <= 1'b0;
    end else if (step_bin) begin
      b_reg <= b_inc;
      r_reg <= counts[b_inc];
    end else begin
      if (to_fill)
        fill_reg <= 1'b1;
      if (dec && !r_zero)
        r_reg <= r_reg - 1'b1;
    end
  end

endmodule

// File: rtl/led_frame_serializer.sv
// Snapshots one visualizer frame and streams LEDS pixels (bin colours repeated
// by their counts, black tail) over a valid/ready link to the strip driver.
module led_frame_serializer
  import led_frame_serializer_pkg::*;
#(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int CW      = $clog2(LEDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BIN_QTY-1:0][23:0]    rgb,
  input  logic [BIN_QTY-1:0][CW-1:0]  LEDCounts,
  input  logic                        data_v,
  output rgb_t                        pix_data,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic                        pix_last,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_drop
);

  localparam logic [CW-1:0] P_LAST = CW'(LEDS - 1);

  ser_state_t                  state_reg;
  logic [BIN_QTY-1:0][23:0]    snap_rgb_reg;
  logic [BIN_QTY-1:0][CW-1:0]  snap_cnt_reg;
  logic [CW-1:0]               p_reg;

  rgb_t cur_colour;
  logic fill, r_zero, r_one, b_last;
  logic start, accept, at_last, bin_end, step_bin, to_fill, dec;

  assign start    = (state_reg == IDLE) && data_v;
  assign accept   = (state_reg == STREAM) && pix_valid && pix_ready;
  assign at_last  = (p_reg == P_LAST);
  assign bin_end  = accept && !at_last && !fill && r_one;
  assign step_bin = ((state_reg == SEEK) && r_zero && !b_last) || (bin_end && !b_last);
  assign to_fill  = ((state_reg == SEEK) && r_zero && b_last) || (bin_end && b_last);
  assign dec      = accept && !at_last;

  led_bin_cursor #(
    .BIN_QTY (BIN_QTY),
    .CW      (CW)
  ) u_cursor (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_count (LEDCounts[0]),
    .step_bin    (step_bin),
    .dec         (dec),
    .to_fill     (to_fill),
    .counts      (snap_cnt_reg),
    .colours     (snap_rgb_reg),
    .colour      (cur_colour),
    .fill        (fill),
    .r_zero      (r_zero),
    .r_one       (r_one),
    .b_last      (b_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      snap_rgb_reg <= '0;
      snap_cnt_reg <= '0;
      p_reg        <= '0;
      pix_data     <= BLACK;
      pix_valid    <= 1'b0;
      pix_last     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_drop   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (data_v) begin
            snap_rgb_reg <= rgb;
            snap_cnt_reg <= LEDCounts;
            p_reg        <= '0;
            busy         <= 1'b1;
            state_reg    <= SEEK;
          end
        end
        SEEK: begin
          frame_drop <= data_v;
          if (!r_zero || b_last) begin
            state_reg <= STREAM;
            pix_valid <= 1'b1;
            pix_data  <= r_zero ? BLACK : cur_colour;
            pix_last  <= at_last;
          end
        end
        STREAM: begin
          frame_drop <= data_v;
          if (accept) begin
            if (at_last) begin
              state_reg  <= DONE;
              pix_valid  <= 1'b0;
              pix_last   <= 1'b0;
              pix_data   <= BLACK;
              frame_done <= 1'b1;
            end else begin
              p_reg    <= p_reg + 1'b1;
              pix_last <= ((p_reg + 1'b1) == P_LAST);
              if (bin_end && b_last) begin
                pix_data <= BLACK;
              end else if (bin_end) begin
                state_reg <= SEEK;
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          frame_drop <= data_v;
          busy       <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Randomized and directed frames checked against a pixel/timing list model.
module tb_led_frame_serializer;

  localparam int LEDS    = 50;
  localparam int BIN_QTY = 12;
  localparam int CW      = $clog2(LEDS);

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic [BIN_QTY-1:0][23:0]    rgb = '0;
  logic [BIN_QTY-1:0][CW-1:0]  led_counts = '0;
  logic                        data_v = 1'b0;
  logic                        pix_ready = 1'b0;
  logic [23:0]                 pix_data;
  logic                        pix_valid, pix_last, busy, frame_done, frame_drop;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] f_rgb [BIN_QTY];
  int          f_cnt [BIN_QTY];
  logic [23:0] exp_pix [LEDS];
  int          exp_cyc [LEDS];

  led_frame_serializer #(.LEDS(LEDS), .BIN_QTY(BIN_QTY), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rgb        (rgb),
    .LEDCounts  (led_counts),
    .data_v     (data_v),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected pixel list plus the cycle (relative to the data_v cycle) each
  // pixel is presented when the sink is always ready.
  task automatic build_model();
    int n, b, t, c;
    n = 0; b = 0; t = 1;
    while (n < LEDS) begin
      while (f_cnt[b] == 0 && b < BIN_QTY - 1) begin
        t++; b++;
      end
      t++;
      if (f_cnt[b] == 0) begin
        while (n < LEDS) begin exp_pix[n] = 24'h0; exp_cyc[n] = t; n++; t++; end
      end else begin
        c = f_cnt[b];
        while (c > 0 && n < LEDS) begin exp_pix[n] = f_rgb[b]; exp_cyc[n] = t; n++; t++; c--; end
        if (n < LEDS && b == BIN_QTY - 1) begin
          while (n < LEDS) begin exp_pix[n] = 24'h0; exp_cyc[n] = t; n++; t++; end
        end else if (n < LEDS) begin
          b++;
        end
      end
    end
  endtask

  // rmode: 0 always ready, 1 ready pattern 1-0-0-1, 2 random ready.
  task automatic run_frame(input string name, input int rmode, input bit drops, input int abort_at);
    int n, c, last_c, done_cnt, drop_cnt, drop_at;
    bit first_seen, stall, fin;
    logic [23:0] hold_d;
    logic hold_l;
    n = 0; c = 0; last_c = -1; done_cnt = 0; drop_cnt = 0;
    first_seen = 0; stall = 0; fin = 0; hold_d = '0; hold_l = 0;
    build_model();
    drop_at = exp_cyc[0] + 5;
    @(negedge clk);
    for (int k = 0; k < BIN_QTY; k++) begin
      rgb[k] = f_rgb[k];
      led_counts[k] = CW'(f_cnt[k]);
    end
    pix_ready = 1'b0;
    data_v = 1'b1;
    while (!fin) begin
      @(negedge clk);
      c++;
      data_v = 1'b0;
      if (c == 1) begin
        for (int k = 0; k < BIN_QTY; k++) begin
          rgb[k] = 24'($urandom);
          led_counts[k] = CW'($urandom);
        end
      end
      if (frame_drop) drop_cnt++;
      if (frame_done) begin
        done_cnt++;
        check_eq({name, " frame_done cycle"}, c, last_c + 1);
        if (drops) data_v = 1'b1;
      end
      if (pix_valid && !first_seen) begin
        first_seen = 1;
        check_eq({name, " first valid cycle"}, c, exp_cyc[0]);
      end
      if (stall) begin
        check_eq({name, " valid held in stall"}, pix_valid, 1);
        check_eq({name, " data held in stall"}, pix_data, hold_d);
        check_eq({name, " last held in stall"}, pix_last, hold_l);
      end
      case (rmode)
        0: pix_ready = 1'b1;
        1: pix_ready = (c % 4 == 0) || (c % 4 == 3);
        default: pix_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (drops && c == drop_at) data_v = 1'b1;
      if (pix_valid && pix_ready) begin
        if (n < LEDS) begin
          check_eq($sformatf("%s pixel %0d data", name, n), pix_data, exp_pix[n]);
          check_eq($sformatf("%s pixel %0d last", name, n), pix_last, (n == LEDS - 1));
          if (rmode == 0)
            check_eq($sformatf("%s pixel %0d cycle", name, n), c, exp_cyc[n]);
        end
        n++;
        if (n == LEDS) last_c = c;
      end
      stall  = pix_valid && !pix_ready;
      hold_d = pix_data;
      hold_l = pix_last;
      if (abort_at > 0 && n == abort_at) begin
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq({name, " abort pix_valid"}, pix_valid, 0);
        check_eq({name, " abort busy"}, busy, 0);
        check_eq({name, " abort pix_last"}, pix_last, 0);
        repeat (3) begin
          @(negedge clk);
          check_eq({name, " abort no frame_done"}, frame_done, 0);
        end
        rst = 1'b1;
        data_v = 1'b0;
        return;
      end
      if (last_c >= 0 && c > last_c + 2) fin = 1;
      if (c > 1500) fin = 1;
    end
    check_eq({name, " accepts"}, n, LEDS);
    check_eq({name, " frame_done pulses"}, done_cnt, 1);
    check_eq({name, " frame_drop pulses"}, drop_cnt, drops ? 2 : 0);
    check_eq({name, " idle busy"}, busy, 0);
    check_eq({name, " idle valid"}, pix_valid, 0);
    $display("frame %s: %0d pixels accepted, first valid at T+%0d", name, n, exp_cyc[0]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset pix_valid", pix_valid, 0);
    check_eq("reset busy", busy, 0);
    check_eq("reset pix_data", pix_data, 0);
    check_eq("reset pix_last", pix_last, 0);
    check_eq("reset frame_done", frame_done, 0);
    check_eq("reset frame_drop", frame_drop, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle busy", busy, 0);

    for (int k = 0; k < BIN_QTY; k++) begin
      f_rgb[k] = 24'h010000 * k;
      f_cnt[k] = 4;
    end
    run_frame("abort", 0, 0, 20);
    run_frame("full", 0, 0, 0);
    run_frame("drop", 0, 1, 0);

    for (int k = 0; k < BIN_QTY; k++) begin
      f_rgb[k] = 24'($urandom);
      f_cnt[k] = (k < 2) ? 30 : 0;
    end
    run_frame("overflow", 0, 0, 0);

    for (int k = 0; k < BIN_QTY; k++) begin
      f_rgb[k] = 24'($urandom);
      f_cnt[k] = 0;
    end
    f_rgb[5] = 24'hFFAA00;
    f_cnt[5] = 3;
    run_frame("zero_bins", 1, 0, 0);

    f_cnt[5] = 0;
    run_frame("all_zero", 0, 0, 0);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < BIN_QTY; k++) begin
        f_rgb[k] = 24'($urandom);
        if (i == 4) f_cnt[k] = $urandom_range(40, 63);
        else        f_cnt[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 9);
      end
      run_frame($sformatf("rand%0d", i), i % 3, i[0], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
